// File: rtl/clock_calendar_core.sv
// Clock/calendar datapath: 1 Hz prescaler, increment-button synchronizer and the
// time/date registers, advanced by the tick in NORMAL or by presses in set modes.
module clock_calendar_core #(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] state,
    input  logic       inc_button,
    output logic [5:0] sec,
    output logic [5:0] min,
    output logic [4:0] hour,
    output logic [4:0] day,
    output logic [3:0] month,
    output logic [6:0] year,
    output logic       tick_1hz
);
    localparam int            PW      = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(CLK_HZ - 1);

    localparam logic [2:0] M_SS = 3'd1;
    localparam logic [2:0] M_MI = 3'd2;
    localparam logic [2:0] M_HH = 3'd3;
    localparam logic [2:0] M_DD = 3'd4;
    localparam logic [2:0] M_MO = 3'd5;
    localparam logic [2:0] M_YY = 3'd6;

    logic [PW-1:0] pre_cnt;
    logic          pre_wrap;
    logic          s1, s2, prev, inc_pulse;
    logic          normal;

    logic [5:0] sec_n, min_n, sec_inc, min_inc;
    logic [4:0] hour_n, day_n, hour_inc, day_inc, dim_cur, dim_mo;
    logic [3:0] month_n, month_inc;
    logic [6:0] year_n, year_inc;

    // Every year divisible by 4 in 2000..2099 is a leap year, so two bits suffice.
    function automatic logic [4:0] days_in(input logic [3:0] m, input logic [1:0] yl);
        case (m)
            4'd4, 4'd6, 4'd9, 4'd11: days_in = 5'd30;
            4'd2:                    days_in = (yl == 2'd0) ? 5'd29 : 5'd28;
            default:                 days_in = 5'd31;
        endcase
    endfunction

    assign pre_wrap  = (pre_cnt == PRE_MAX);
    assign inc_pulse = s2 & ~prev;
    assign normal    = (state == 3'd0) || (state == 3'd7);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_cnt  <= '0;
            tick_1hz <= 1'b0;
            s1       <= 1'b0;
            s2       <= 1'b0;
            prev     <= 1'b0;
        end else begin
            pre_cnt  <= pre_wrap ? '0 : pre_cnt + PW'(1);
            tick_1hz <= pre_wrap;
            s1       <= inc_button;
            s2       <= s1;
            prev     <= s2;
        end
    end

    always_comb begin
        sec_n     = sec;
        min_n     = min;
        hour_n    = hour;
        day_n     = day;
        month_n   = month;
        year_n    = year;
        sec_inc   = (sec == 6'd59) ? 6'd0 : sec + 6'd1;
        min_inc   = (min == 6'd59) ? 6'd0 : min + 6'd1;
        hour_inc  = (hour == 5'd23) ? 5'd0 : hour + 5'd1;
        dim_cur   = days_in(month, year[1:0]);
        day_inc   = (day >= dim_cur) ? 5'd1 : day + 5'd1;
        month_inc = (month == 4'd12) ? 4'd1 : month + 4'd1;
        year_inc  = (year == 7'd99) ? 7'd0 : year + 7'd1;
        dim_mo    = days_in(month_inc, year[1:0]);

        if (normal) begin
            // The pre-wrap compare is used here so the field moves on the same
            // edge that raises tick_1hz.
            if (pre_wrap) begin
                sec_n = sec_inc;
                if (sec == 6'd59) begin
                    min_n = min_inc;
                    if (min == 6'd59) begin
                        hour_n = hour_inc;
                        if (hour == 5'd23) begin
                            day_n = day_inc;
                            if (day >= dim_cur) begin
                                month_n = month_inc;
                                if (month == 4'd12)
                                    year_n = year_inc;
                            end
                        end
                    end
                end
            end
        end else if (inc_pulse) begin
            case (state)
                M_SS: sec_n  = sec_inc;
                M_MI: min_n  = min_inc;
                M_HH: hour_n = hour_inc;
                M_DD: day_n  = day_inc;
                M_MO: begin
                    month_n = month_inc;
                    if (day > dim_mo)
                        day_n = dim_mo;
                end
                M_YY: begin
                    year_n = year_inc;
                    if ((month == 4'd2) && (day == 5'd29) && (year_inc[1:0] != 2'd0))
                        day_n = 5'd28;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sec   <= 6'd0;
            min   <= 6'd0;
            hour  <= 5'd0;
            day   <= 5'd1;
            month <= 4'd1;
            year  <= 7'd0;
        end else begin
            sec   <= sec_n;
            min   <= min_n;
            hour  <= hour_n;
            day   <= day_n;
            month <= month_n;
            year  <= year_n;
        end
    end
endmodule

// File: tb/tb_clock_calendar_core.sv
// Bench for clock_calendar_core: directed table of set/tick steps, async reset
// and hold checks, then random modes/presses against a calendar model.
module tb_clock_calendar_core;
    localparam int CLK_HZ = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] state = 3'd0;
    logic       inc_button = 1'b0;
    logic [5:0] sec, min;
    logic [4:0] hour, day;
    logic [3:0] month;
    logic [6:0] year;
    logic       tick_1hz;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    clock_calendar_core #(.CLK_HZ(CLK_HZ)) dut (
        .clk(clk), .rst(rst), .state(state), .inc_button(inc_button),
        .sec(sec), .min(min), .hour(hour), .day(day), .month(month), .year(year),
        .tick_1hz(tick_1hz)
    );

    always #5 clk = ~clk;

    // Reference calendar model, advanced at each clock edge.
    int m_sec, m_min, m_hour, m_day, m_month, m_year;
    bit m_tick;
    int k;
    bit h1, h2, h3;
    int dim_tab[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};

    function automatic int dim(input int mo, input int yr);
        if (mo == 2 && (yr % 4) == 0) return 29;
        return dim_tab[mo-1];
    endfunction

    task automatic m_advance();
        m_sec++;
        if (m_sec == 60) begin
            m_sec = 0; m_min++;
            if (m_min == 60) begin
                m_min = 0; m_hour++;
                if (m_hour == 24) begin
                    m_hour = 0; m_day++;
                    if (m_day > dim(m_month, m_year)) begin
                        m_day = 1; m_month++;
                        if (m_month == 13) begin
                            m_month = 1;
                            m_year  = (m_year + 1) % 100;
                        end
                    end
                end
            end
        end
    endtask

    task automatic m_bump(input int md);
        case (md)
            1: m_sec  = (m_sec + 1) % 60;
            2: m_min  = (m_min + 1) % 60;
            3: m_hour = (m_hour + 1) % 24;
            4: m_day  = (m_day >= dim(m_month, m_year)) ? 1 : m_day + 1;
            5: begin
                m_month = m_month % 12 + 1;
                if (m_day > dim(m_month, m_year)) m_day = dim(m_month, m_year);
            end
            6: begin
                m_year = (m_year + 1) % 100;
                if (m_day > dim(m_month, m_year)) m_day = dim(m_month, m_year);
            end
            default: ;
        endcase
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_sec = 0; m_min = 0; m_hour = 0; m_day = 1; m_month = 1; m_year = 0;
            m_tick = 0; k = 0; h1 = 0; h2 = 0; h3 = 0;
        end else begin
            bit wrap, pulse;
            k++;
            wrap  = (k % CLK_HZ) == 0;
            // A rise sampled at edge N takes effect at edge N+2.
            pulse = h2 && !h3;
            h3 = h2; h2 = h1; h1 = inc_button;
            if (state == 3'd0 || state == 3'd7) begin
                if (wrap) m_advance();
            end else if (pulse) begin
                m_bump(int'(state));
            end
            m_tick = wrap;
        end
    end

    always @(negedge clk) begin
        if (chk_en && rst) begin
            n_checks++;
            if (sec === 6'(m_sec) && min === 6'(m_min) && hour === 5'(m_hour) &&
                day === 5'(m_day) && month === 4'(m_month) && year === 7'(m_year) &&
                tick_1hz === m_tick)
                n_pass++;
            else
                $display("FAIL model t=%0t: got %0d:%0d:%0d %0d/%0d/%0d tick=%0b, expected %0d:%0d:%0d %0d/%0d/%0d tick=%0b",
                         $time, sec, min, hour, day, month, year, tick_1hz,
                         m_sec, m_min, m_hour, m_day, m_month, m_year, m_tick);
        end
    end

    task automatic check_time(input string name, input int s, input int mi, input int h,
                              input int d, input int mo, input int y);
        n_checks++;
        if (sec === 6'(s) && min === 6'(mi) && hour === 5'(h) &&
            day === 5'(d) && month === 4'(mo) && year === 7'(y))
            n_pass++;
        else
            $display("FAIL %s: got %0d:%0d:%0d %0d/%0d/%0d, expected %0d:%0d:%0d %0d/%0d/%0d",
                     name, sec, min, hour, day, month, year, s, mi, h, d, mo, y);
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    endtask

    task automatic press(input int hold);
        @(negedge clk);
        inc_button = 1'b1;
        repeat (hold) @(negedge clk);
        inc_button = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_tick(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 3 * CLK_HZ && !seen; i++) begin
            @(negedge clk);
            seen = tick_1hz;
        end
        check_int(name, int'(seen), 1);
    endtask

    typedef struct {
        logic [2:0] mode;
        int n, s, mi, h, d, mo, y;
    } row_t;

    row_t rows[31];

    initial begin
        logic [15:0] tick_mask;
        int cnt;
        bit seen;

        rows[0]  = '{3'd1, 58, 58,  0,  0,  1,  1,  0};
        rows[1]  = '{3'd2, 59, 58, 59,  0,  1,  1,  0};
        rows[2]  = '{3'd3, 23, 58, 59, 23,  1,  1,  0};
        rows[3]  = '{3'd4, 30, 58, 59, 23, 31,  1,  0};
        rows[4]  = '{3'd5,  1, 58, 59, 23, 29,  2,  0};
        rows[5]  = '{3'd6,  1, 58, 59, 23, 28,  2,  1};
        rows[6]  = '{3'd6, 98, 58, 59, 23, 28,  2, 99};
        rows[7]  = '{3'd5, 10, 58, 59, 23, 28, 12, 99};
        rows[8]  = '{3'd4,  3, 58, 59, 23, 31, 12, 99};
        rows[9]  = '{3'd1,  1, 59, 59, 23, 31, 12, 99};
        rows[10] = '{3'd0,  0,  0,  0,  0,  1,  1,  0};
        rows[11] = '{3'd1, 59, 59,  0,  0,  1,  1,  0};
        rows[12] = '{3'd2, 59, 59, 59,  0,  1,  1,  0};
        rows[13] = '{3'd3, 23, 59, 59, 23,  1,  1,  0};
        rows[14] = '{3'd4, 27, 59, 59, 23, 28,  1,  0};
        rows[15] = '{3'd5,  1, 59, 59, 23, 28,  2,  0};
        rows[16] = '{3'd6, 23, 59, 59, 23, 28,  2, 23};
        rows[17] = '{3'd0,  0,  0,  0,  0,  1,  3, 23};
        rows[18] = '{3'd1, 59, 59,  0,  0,  1,  3, 23};
        rows[19] = '{3'd2, 59, 59, 59,  0,  1,  3, 23};
        rows[20] = '{3'd3, 23, 59, 59, 23,  1,  3, 23};
        rows[21] = '{3'd5, 11, 59, 59, 23,  1,  2, 23};
        rows[22] = '{3'd4, 27, 59, 59, 23, 28,  2, 23};
        rows[23] = '{3'd6,  1, 59, 59, 23, 28,  2, 24};
        rows[24] = '{3'd7,  0,  0,  0,  0, 29,  2, 24};
        rows[25] = '{3'd4,  1,  0,  0,  0,  1,  2, 24};
        rows[26] = '{3'd3, 25,  0,  0,  1,  1,  2, 24};
        rows[27] = '{3'd5,  2,  0,  0,  1,  1,  4, 24};
        rows[28] = '{3'd4, 29,  0,  0,  1, 30,  4, 24};
        rows[29] = '{3'd5,  1,  0,  0,  1, 30,  5, 24};
        rows[30] = '{3'd0,  0,  1,  0,  1, 30,  5, 24};

        repeat (3) @(negedge clk);
        check_time("reset", 0, 0, 0, 1, 1, 0);
        check_int("reset_tick", int'(tick_1hz), 0);
        rst    = 1'b1;
        chk_en = 1'b1;

        tick_mask = '0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (tick_1hz) tick_mask[i] = 1'b1;
        end
        check_int("tick_spacing", int'(tick_mask), 'h8888);
        check_time("normal_16", 4, 0, 0, 1, 1, 0);

        // Land just after a tick edge so tick_1hz is high when reset hits.
        repeat (4) @(negedge clk);
        check_int("pre_reset_tick", int'(tick_1hz), 1);
        #2 rst = 1'b0;
        #1;
        check_time("async_reset", 0, 0, 0, 1, 1, 0);
        check_int("async_reset_tick", int'(tick_1hz), 0);
        @(negedge clk);
        rst = 1'b1;
        cnt = 0;
        seen = 1'b0;
        for (int i = 0; i < 3 * CLK_HZ && !seen; i++) begin
            @(negedge clk);
            cnt++;
            seen = tick_1hz;
        end
        check_int("restart_ticks", cnt, CLK_HZ);
        check_time("restart_sec", 1, 0, 0, 1, 1, 0);

        @(negedge clk); rst = 1'b0;
        @(negedge clk); rst = 1'b1;

        for (int r = 0; r < 31; r++) begin
            @(negedge clk);
            state = rows[r].mode;
            if (rows[r].mode == 3'd0 || rows[r].mode == 3'd7)
                wait_tick($sformatf("row%0d_tick", r));
            else
                repeat (rows[r].n) press(3);
            check_time($sformatf("row%0d", r), rows[r].s, rows[r].mi, rows[r].h,
                       rows[r].d, rows[r].mo, rows[r].y);
        end

        @(negedge clk);
        state = 3'd1;
        repeat (57) press(3);
        check_time("ss_58", 58, 0, 1, 30, 5, 24);
        press(10);
        check_time("ss_59", 59, 0, 1, 30, 5, 24);
        press(10);
        check_time("ss_wrap", 0, 0, 1, 30, 5, 24);
        press(10);
        check_time("ss_1", 1, 0, 1, 30, 5, 24);
        press(100);
        check_time("ss_hold", 2, 0, 1, 30, 5, 24);
        repeat (20) @(negedge clk);
        check_time("ss_frozen", 2, 0, 1, 30, 5, 24);

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 15) == 0) state = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) inc_button = ~inc_button;
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/clock_calendar_core.md
Name: clock_calendar_core

Overview:
Timekeeping datapath that sits directly downstream of the display/set-mode FSM. It consumes the FSM's 3-bit mode code and a debounced increment button. It keeps seconds, minutes, hours, day, month and 2-digit year. In NORMAL mode it advances once per second. In any set mode it freezes and increments only the selected field, once per button press.

Parameters:
CLK_HZ, 50_000_000, clk frequency; the 1 Hz prescaler counts 0..CLK_HZ-1.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-low reset
state  input  3  mode code from the mode FSM: 0 NORMAL, 1 SS, 2 MI, 3 HH, 4 DD, 5 MO, 6 YY; 7 is treated as NORMAL
inc_button  input  1  debounced increment button, active-high level, asynchronous to clk
sec  output  6  seconds, 0..59
min  output  6  minutes, 0..59
hour  output  5  hours, 0..23
day  output  5  day of month, 1..days_in_month
month  output  4  month, 1..12
year  output  7  year 0..99, meaning 2000..2099
tick_1hz  output  1  one-cycle pulse when the prescaler wraps

Behaviour:
- Reset (rst low, async): sec=0, min=0, hour=0, day=1, month=1, year=0; prescaler=0; sync flops=0; tick_1hz=0.
- Prescaler:
  - Free-runs in every mode. Counts 0..CLK_HZ-1, then wraps to 0.
  - tick_1hz is registered. It is high for the one cycle after the count reaches CLK_HZ-1.
- Button path:
  - Two-flop synchronizer (s1, s2) plus a prev register.
  - inc_pulse = s2 & ~prev.
  - If inc_button rises before clk edge N, the field update lands on edge N+2.
  - One press gives exactly one increment, however long the button is held.
- NORMAL mode (state 0 or 7): on tick_1hz, sec increments with full carry chain.
  - sec 59->0 carries into min; min 59->0 carries into hour; hour 23->0 carries into day.
  - day == days_in_month -> day=1, carry into month.
  - month 12->1, carry into year; year 99->0.
  - inc_pulse is ignored.
- days_in_month:
  - 31 for months 1, 3, 5, 7, 8, 10, 12.
  - 30 for months 4, 6, 9, 11.
  - February: 29 if year[1:0]==0, else 28. Year 0 (2000) is leap.
- Set modes (1..6): tick_1hz is ignored, so time is frozen. On inc_pulse only the selected field changes, with no carry into neighbouring fields.
  - SS: sec +1, 59 wraps to 0.
  - MI: min +1, 59 wraps to 0.
  - HH: hour +1, 23 wraps to 0.
  - DD: day +1; at days_in_month it wraps to 1.
  - MO: month +1, 12 wraps to 1; then day clamps to the new days_in_month if it exceeds it.
  - YY: year +1, 99 wraps to 0; then day clamps if Feb 29 lands on a non-leap year (day becomes 28).
  - Clamp and increment complete in the same clock edge; no transient illegal value is visible.
- Mode changes:
  - The mode change takes effect on the cycle state changes.
  - A tick that coincides with the cycle state leaves NORMAL is dropped.
  - A press in flight while state changes applies to the mode present on the update edge.
- Reset mid-operation restores reset values immediately, independent of clk.
- Outputs are registered and always hold legal values; no combinational path from inputs to outputs.

Test Plan:
1. Set CLK_HZ=4. Release reset, hold NORMAL for 16 cycles -> tick_1hz pulses every 4 cycles; sec reads 4; other fields at reset values.
2. Set mode to 23:59:59, 31/12/99, then NORMAL, then one tick -> 00:00:00, day=1, month=1, year=0.
3. Set Feb 28, year 23, 23:59:59; one tick -> Mar 1. Repeat with year 24 -> Feb 29.
4. state=SS, sec=58, three presses of 10 cycles each -> sec 59, 0, 1; min unchanged. A 100-cycle hold gives only one increment. Ticks during SS do not change sec.
5. day=31, month=1; state=MO, one press -> month=2, day=29 (year 0). Then state=YY, one press -> year=1, day=28.
6. Assert rst low mid-count while in NORMAL -> all outputs return to reset values with no clock edge. Release rst -> counting restarts from prescaler 0.
